// File: rtl/mem_port_arbiter_if.sv
// Bundle of the fetch, load/store and shared-memory handshake signals around mem_port_arbiter.
// master = arbiter side, slave = core/memory side.
interface mem_port_arbiter_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
);
  logic              inst_req;
  logic [ADDR_W-1:0] inst_addr;
  logic              inst_addr_ok;
  logic              inst_data_ok;
  logic [DATA_W-1:0] inst_rdata;

  logic              data_req;
  logic              data_wr;
  logic [3:0]        data_wstrb;
  logic [ADDR_W-1:0] data_addr;
  logic [DATA_W-1:0] data_wdata;
  logic              data_addr_ok;
  logic              data_data_ok;
  logic [DATA_W-1:0] data_rdata;

  logic              mem_req;
  logic              mem_wr;
  logic [3:0]        mem_wstrb;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic              mem_addr_ok;
  logic              mem_data_ok;
  logic [DATA_W-1:0] mem_rdata;

  logic              stallreq_from_arb;
  logic              bus_err;

  modport master (
    input  inst_req, inst_addr,
    input  data_req, data_wr, data_wstrb, data_addr, data_wdata,
    input  mem_addr_ok, mem_data_ok, mem_rdata,
    output inst_addr_ok, inst_data_ok, inst_rdata,
    output data_addr_ok, data_data_ok, data_rdata,
    output mem_req, mem_wr, mem_wstrb, mem_addr, mem_wdata,
    output stallreq_from_arb, bus_err
  );

  modport slave (
    output inst_req, inst_addr,
    output data_req, data_wr, data_wstrb, data_addr, data_wdata,
    output mem_addr_ok, mem_data_ok, mem_rdata,
    input  inst_addr_ok, inst_data_ok, inst_rdata,
    input  data_addr_ok, data_data_ok, data_rdata,
    input  mem_req, mem_wr, mem_wstrb, mem_addr, mem_wdata,
    input  stallreq_from_arb, bus_err
  );
endinterface

// File: rtl/mem_port_arbiter.sv
// Shares one SRAM-like port between fetch and load/store, one outstanding transaction at a time.
// Define ARB_ROUND_ROBIN_EN for round-robin tie-break; default is fixed data priority.
module mem_port_arbiter #(
  parameter int ADDR_W      = 32,
  parameter int DATA_W      = 32,
  parameter int TIMEOUT_CYC = 255
) (
  input logic                clk,
  input logic                rst,
  mem_port_arbiter_if.master bus
);

  typedef enum logic [1:0] {S_IDLE, S_REQ, S_RESP} state_e;
  typedef enum logic {OWN_DATA = 1'b0, OWN_INST = 1'b1} owner_e;

  localparam logic [7:0] TIMEOUT_V = 8'(TIMEOUT_CYC);

  state_e            state_q, state_d;
  owner_e            owner_q, owner_d;
  logic              mem_wr_q, mem_wr_d;
  logic [3:0]        mem_wstrb_q, mem_wstrb_d;
  logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
  logic [DATA_W-1:0] mem_wdata_q, mem_wdata_d;
  logic [7:0]        cnt_q, cnt_d;

  logic              grant_data;
  logic              addr_ok;
  logic              data_ok;
  logic              abort;
  logic [DATA_W-1:0] rdata;

`ifdef ARB_ROUND_ROBIN_EN
  owner_e last_owner_q, last_owner_d;

  // On a tie, grant whichever side did not win the previous grant.
  always_comb begin
    if (bus.inst_req && bus.data_req) begin
      grant_data = (last_owner_q == OWN_INST);
    end else begin
      grant_data = bus.data_req;
    end
  end

  always_comb begin
    last_owner_d = last_owner_q;
    if (state_q == S_IDLE && (bus.inst_req || bus.data_req)) begin
      last_owner_d = grant_data ? OWN_DATA : OWN_INST;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      last_owner_q <= OWN_DATA;
    end else begin
      last_owner_q <= last_owner_d;
    end
  end
`else
  assign grant_data = bus.data_req;
`endif

  always_comb begin
    state_d     = state_q;
    owner_d     = owner_q;
    mem_wr_d    = mem_wr_q;
    mem_wstrb_d = mem_wstrb_q;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    cnt_d       = cnt_q;
    addr_ok     = 1'b0;
    data_ok     = 1'b0;
    abort       = 1'b0;
    rdata       = '0;
    case (state_q)
      S_IDLE: begin
        if (bus.inst_req || bus.data_req) begin
          state_d = S_REQ;
          cnt_d   = '0;
          if (grant_data) begin
            owner_d     = OWN_DATA;
            mem_wr_d    = bus.data_wr;
            mem_wstrb_d = bus.data_wstrb;
            mem_addr_d  = bus.data_addr;
            mem_wdata_d = bus.data_wdata;
          end else begin
            owner_d     = OWN_INST;
            mem_wr_d    = 1'b0;
            mem_wstrb_d = 4'h0;
            mem_addr_d  = bus.inst_addr;
            mem_wdata_d = '0;
          end
        end
      end
      S_REQ: begin
        cnt_d = cnt_q + 8'd1;
        if (cnt_q == TIMEOUT_V) begin
          abort   = 1'b1;
          data_ok = 1'b1;
          state_d = S_IDLE;
        end else if (bus.mem_addr_ok) begin
          addr_ok = 1'b1;
          state_d = S_RESP;
        end
      end
      S_RESP: begin
        cnt_d = cnt_q + 8'd1;
        // A real response beats a timeout landing in the same cycle.
        if (bus.mem_data_ok) begin
          data_ok = 1'b1;
          rdata   = bus.mem_rdata;
          state_d = S_IDLE;
        end else if (cnt_q == TIMEOUT_V) begin
          abort   = 1'b1;
          data_ok = 1'b1;
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= S_IDLE;
      owner_q     <= OWN_DATA;
      mem_wr_q    <= 1'b0;
      mem_wstrb_q <= 4'h0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      cnt_q       <= '0;
    end else begin
      state_q     <= state_d;
      owner_q     <= owner_d;
      mem_wr_q    <= mem_wr_d;
      mem_wstrb_q <= mem_wstrb_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      cnt_q       <= cnt_d;
    end
  end

  assign bus.inst_addr_ok = addr_ok && (owner_q == OWN_INST);
  assign bus.inst_data_ok = data_ok && (owner_q == OWN_INST);
  assign bus.inst_rdata   = (owner_q == OWN_INST) ? rdata : '0;
  assign bus.data_addr_ok = addr_ok && (owner_q == OWN_DATA);
  assign bus.data_data_ok = data_ok && (owner_q == OWN_DATA);
  assign bus.data_rdata   = (owner_q == OWN_DATA) ? rdata : '0;

  assign bus.mem_req   = (state_q == S_REQ);
  assign bus.mem_wr    = mem_wr_q;
  assign bus.mem_wstrb = mem_wstrb_q;
  assign bus.mem_addr  = mem_addr_q;
  assign bus.mem_wdata = mem_wdata_q;
  assign bus.bus_err   = abort;

  assign bus.stallreq_from_arb =
      ((state_q != S_IDLE) && !(state_q == S_RESP && bus.mem_data_ok)) ||
      ((state_q == S_IDLE) && (bus.inst_req || bus.data_req));

endmodule
